// File: rtl/bitwise_accum_pkg.sv
// Shared definitions for the bitwise reduction accumulator: op encoding,
// FSM state type and the op used when folding a beat into the accumulator.
package bitwise_accum_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic {
        StAcc  = 1'b0,
        StDone = 1'b1
    } state_t;

    // NAND packets fold with plain AND; the inversion is applied on output only.
    function automatic logic [1:0] fold_op(input logic [1:0] op);
        return (op == OP_NAND) ? OP_AND : op;
    endfunction

endpackage

// File: rtl/bitwise_op.sv
// Stateless WIDTH-bit word operation: AND, OR, XOR or NAND of a and b.
module bitwise_op
    import bitwise_accum_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_accum.sv
// Packet-wise bitwise reduction: folds every accepted beat into one word with
// the op latched on the first beat, then presents the result until consumed.
module bitwise_accum
    import bitwise_accum_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero
);

    state_t             r_state;
    state_t             w_state_d;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;
    logic [1:0]         r_op;

    logic               w_ready;
    logic               w_accept;
    logic               w_first;
    logic [WIDTH-1:0]   w_fold;

    // Gated by rst_n so in_ready is low throughout reset, not just after the first edge.
    assign w_ready  = (r_state == StAcc) && rst_n;
    assign w_accept = in_valid && w_ready;
    assign w_first  = (r_count == '0);
    assign in_ready = w_ready;

    bitwise_op #(
        .WIDTH (WIDTH)
    ) u_op (
        .a  (r_acc),
        .b  (in_data),
        .op (fold_op(r_op)),
        .y  (w_fold)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StAcc;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        out_valid = 1'b0;
        out_data  = '0;
        out_count = '0;
        out_zero  = 1'b0;
        unique case (r_state)
            StAcc: begin
                if (w_accept && in_last) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                out_data  = (r_op == OP_NAND) ? ~r_acc : r_acc;
                out_count = r_count;
                out_zero  = (out_data == '0);
                if (out_ready) begin
                    w_state_d = StAcc;
                end
            end
            default: w_state_d = StAcc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_count <= '0;
            r_op    <= OP_AND;
        end else if (w_accept) begin
            if (w_first) begin
                r_acc <= in_data;
                r_op  <= op;
            end else begin
                r_acc <= w_fold;
            end
            if (r_count != '1) begin
                r_count <= r_count + 1'b1;
            end
        end else if ((r_state == StDone) && out_ready) begin
            r_count <= '0;
        end
    end

endmodule

// File: tb/tb_bitwise_accum.sv
// Bench for bitwise_accum: directed scenarios plus randomized traffic, checked
// every cycle against a packet-level model (two DUTs: CNT_W=8 and CNT_W=2).
module tb_bitwise_accum;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     = 1'b0;
    logic [1:0]  op        = 2'b00;
    logic        in_valid  = 1'b0;
    logic        in_last   = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_data   = 16'h0;

    logic        in_ready, out_valid, out_zero;
    logic [15:0] out_data;
    logic [7:0]  out_count;
    logic        in_ready2, out_valid2, out_zero2;
    logic [15:0] out_data2;
    logic [1:0]  out_count2;

    int checks = 0;
    int errors = 0;

    bitwise_accum #(.WIDTH(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count), .out_zero(out_zero)
    );

    bitwise_accum #(.WIDTH(16), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .op(op), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_count(out_count2), .out_zero(out_zero2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: collect beats, reduce once the last beat arrives.
    logic [15:0] q[$];
    logic [1:0]  m_op;
    bit          m_done;
    logic [15:0] m_res;
    int          m_n;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_done = 1'b0;
            q.delete();
        end else if (m_done) begin
            if (out_ready) begin
                m_done = 1'b0;
                q.delete();
            end
        end else if (in_valid) begin
            if (q.size() == 0) m_op = op;
            q.push_back(in_data);
            if (in_last) begin
                m_res = q[0];
                for (int i = 1; i < q.size(); i++) begin
                    case (m_op)
                        2'b01:   m_res = m_res | q[i];
                        2'b10:   m_res = m_res ^ q[i];
                        default: m_res = m_res & q[i];
                    endcase
                end
                if (m_op == 2'b11) m_res = ~m_res;
                m_n    = q.size();
                m_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] e_data;
        int          e_cnt, e_cnt2;
        e_data = m_done ? m_res : 16'h0;
        e_cnt  = m_done ? ((m_n > 255) ? 255 : m_n) : 0;
        e_cnt2 = m_done ? ((m_n > 3) ? 3 : m_n) : 0;
        chk("in_ready",   in_ready,   rst_n && !m_done);
        chk("out_valid",  out_valid,  m_done);
        chk("out_data",   out_data,   e_data);
        chk("out_count",  out_count,  e_cnt);
        chk("out_zero",   out_zero,   m_done && (m_res == 16'h0));
        chk("in_ready2",  in_ready2,  rst_n && !m_done);
        chk("out_valid2", out_valid2, m_done);
        chk("out_data2",  out_data2,  e_data);
        chk("out_count2", out_count2, e_cnt2);
        chk("out_zero2",  out_zero2,  m_done && (m_res == 16'h0));
    end

    task automatic send(input logic [1:0] o, input logic [15:0] d, input logic l);
        int n    = 0;
        bit took = 1'b0;
        op = o; in_data = d; in_last = l; in_valid = 1'b1;
        while (!took && n < 50) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!took) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no in_ready expected in_ready within 50 cycles");
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // AND of three beats
        send(2'b00, 16'hFFFF, 1'b0);
        send(2'b00, 16'h0F0F, 1'b0);
        send(2'b00, 16'h00FF, 1'b1);
        @(negedge clk);
        chk("and_valid", out_valid, 1);
        chk("and_data", out_data, 16'h000F);
        chk("and_model", m_res, 16'h000F);
        chk("and_count", out_count, 3);
        chk("and_zero", out_zero, 0);
        take();

        // Single-beat NAND
        send(2'b11, 16'hFFFF, 1'b1);
        @(negedge clk);
        chk("nand_data", out_data, 16'h0000);
        chk("nand_count", out_count, 1);
        chk("nand_zero", out_zero, 1);
        take();

        // Op change after the first beat is ignored; then back-pressure in DONE
        send(2'b10, 16'h1234, 1'b0);
        send(2'b01, 16'h1234, 1'b1);
        @(negedge clk);
        chk("xor_data", out_data, 16'h0000);
        chk("xor_model", m_res, 16'h0000);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 16'hABCD; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_data", out_data, 16'h0000);
            chk("hold_count", out_count, 2);
            @(posedge clk); #1;
        end
        take();
        @(negedge clk);
        chk("after_hs_ready", in_ready, 1);
        chk("after_hs_count", out_count, 0);
        in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;

        // Six OR beats: CNT_W=2 instance saturates at 3
        send(2'b01, 16'h0001, 1'b0);
        send(2'b01, 16'h0002, 1'b0);
        send(2'b01, 16'h0004, 1'b0);
        send(2'b01, 16'h0008, 1'b0);
        send(2'b01, 16'h0100, 1'b0);
        send(2'b01, 16'h8000, 1'b1);
        @(negedge clk);
        chk("sat_count2", out_count2, 3);
        chk("sat_count", out_count, 6);
        chk("sat_data2", out_data2, 16'h810F);
        take();

        // Reset mid-packet discards it
        send(2'b00, 16'h1111, 1'b0);
        send(2'b00, 16'h2222, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_valid", out_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(2'b00, 16'h00AA, 1'b1);
        @(negedge clk);
        chk("postrst_valid", out_valid, 1);
        chk("postrst_data", out_data, 16'h00AA);
        chk("postrst_count", out_count, 1);
        take();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(199) == 0) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            in_valid  = ($urandom_range(9) < 7);
            op        = 2'($urandom_range(3));
            case ($urandom_range(3))
                0:       in_data = 16'hFFFF;
                1:       in_data = 16'h0000;
                default: in_data = 16'($urandom());
            endcase
            in_last   = ($urandom_range(3) == 0);
            out_ready = ($urandom_range(1) == 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
